// File: rtl/led_pkg.sv
// Shared types and helpers for the LED driver.
//   led_op_e    : command opcodes carried on cmd_mode (values 5-7 are reserved)
//   led_state_e : LED controller states
//   tick_cycles : clock cycles per timebase tick
package led_pkg;

  typedef enum logic [2:0] {
    OP_OFF        = 3'd0,
    OP_ON         = 3'd1,
    OP_BLINK      = 3'd2,
    OP_PULSE      = 3'd3,
    OP_SET_BRIGHT = 3'd4
  } led_op_e;

  typedef enum logic [2:0] {
    S_OFF       = 3'd0,
    S_ON        = 3'd1,
    S_BLINK_ON  = 3'd2,
    S_BLINK_OFF = 3'd3,
    S_PULSE     = 3'd4
  } led_state_e;

  function automatic int unsigned tick_cycles(input int unsigned clk_freq,
                                              input int unsigned tick_hz);
    return clk_freq / tick_hz;
  endfunction

endpackage

// File: rtl/led_driver_if.sv
// Command channel of the LED driver (valid/ready handshake).
//   cmd_valid : command present (master -> slave)
//   cmd_ready : command can be accepted (slave -> master)
//   cmd_mode  : opcode, see led_pkg::led_op_e
//   cmd_arg   : half-period / pulse width in ms, or brightness duty
interface led_driver_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_mode;
  logic [7:0] cmd_arg;

  modport master (output cmd_valid, output cmd_mode, output cmd_arg, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_mode, input cmd_arg, output cmd_ready);
endinterface

// File: rtl/led_driver_tick_gen.sv
// Timebase prescaler: emits a one-cycle tick every TICK_CYCLES clocks.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : restart the count from zero (no tick in the following cycle)
//   tick       : registered, high in the cycle where the count sits at TICK_CYCLES-1
module tick_gen
  import led_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 50_000_000,
  parameter int unsigned TICK_HZ  = 1000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int unsigned TICK_CYCLES = tick_cycles(CLK_FREQ, TICK_HZ);
  localparam int unsigned CW          = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [CW-1:0] LAST      = CW'(TICK_CYCLES - 1);

  logic [CW-1:0] cnt_r;
  logic [CW-1:0] cnt_nxt_s;
  logic          tick_r;

  // next prescaler value: clear, wrap at LAST, or count up
  always_comb begin
    cnt_nxt_s = cnt_r;
    if (clr) begin
      cnt_nxt_s = '0;
    end else if (cnt_r == LAST) begin
      cnt_nxt_s = '0;
    end else begin
      cnt_nxt_s = cnt_r + CW'(1);
    end
  end

  // prescaler register; tick is registered from the next count so it lines up with cnt_r == LAST
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r  <= '0;
      tick_r <= (LAST == '0);
    end else begin
      cnt_r  <= cnt_nxt_s;
      tick_r <= (cnt_nxt_s == LAST);
    end
  end

  assign tick = tick_r;

endmodule

// File: rtl/led_driver.sv
// LED driver: command FSM (OFF/ON/BLINK/PULSE), ms timebase, 8-bit PWM brightness.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : command channel (slave side)
//   led        : registered LED drive, active-high
module led_driver
  import led_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 50_000_000,
  parameter int unsigned TICK_HZ  = 1000
) (
  input  logic           clk,
  input  logic           rst_n,
  led_driver_if.slave    bus,
  output logic           led
);

  led_state_e state_r, state_nxt_s;
  logic [7:0] ms_cnt_r, ms_cnt_nxt_s;
  logic [7:0] period_r, period_nxt_s;
  logic [7:0] bright_r, bright_nxt_s;
  logic [7:0] pwm_r;
  logic       led_r;
  logic       cmd_ready_r;
  logic       accept_s;
  logic       tick_s;
  logic       clr_s;
  logic       lit_s;
  logic [7:0] arg_eff_s;

  assign accept_s  = bus.cmd_valid && cmd_ready_r;
  assign arg_eff_s = (bus.cmd_arg == 8'd0) ? 8'd1 : bus.cmd_arg;

  tick_gen #(
    .CLK_FREQ (CLK_FREQ),
    .TICK_HZ  (TICK_HZ)
  ) u_tick_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr_s),
    .tick  (tick_s)
  );

  // next state: timed transitions first, an accepted state-changing command overrides them
  always_comb begin
    state_nxt_s  = state_r;
    ms_cnt_nxt_s = ms_cnt_r;
    period_nxt_s = period_r;
    bright_nxt_s = bright_r;
    clr_s        = 1'b0;

    if (tick_s) begin
      case (state_r)
        S_BLINK_ON, S_BLINK_OFF, S_PULSE: begin
          if (ms_cnt_r == period_r - 8'd1) begin
            ms_cnt_nxt_s = 8'd0;
            case (state_r)
              S_BLINK_ON:  state_nxt_s = S_BLINK_OFF;
              S_BLINK_OFF: state_nxt_s = S_BLINK_ON;
              default:     state_nxt_s = S_OFF;
            endcase
          end else begin
            ms_cnt_nxt_s = ms_cnt_r + 8'd1;
          end
        end
        default: ms_cnt_nxt_s = ms_cnt_r;
      endcase
    end else begin
      ms_cnt_nxt_s = ms_cnt_r;
    end

    if (accept_s) begin
      case (bus.cmd_mode)
        OP_OFF: state_nxt_s = S_OFF;
        OP_ON:  state_nxt_s = S_ON;
        OP_BLINK: begin
          state_nxt_s  = S_BLINK_ON;
          ms_cnt_nxt_s = 8'd0;
          period_nxt_s = arg_eff_s;
          clr_s        = 1'b1;
        end
        OP_PULSE: begin
          state_nxt_s  = S_PULSE;
          ms_cnt_nxt_s = 8'd0;
          period_nxt_s = arg_eff_s;
          clr_s        = 1'b1;
        end
        OP_SET_BRIGHT: bright_nxt_s = bus.cmd_arg;
        // reserved opcodes complete the handshake and do nothing
        default: bright_nxt_s = bright_r;
      endcase
    end else begin
      clr_s = 1'b0;
    end
  end

  // LED is lit (before brightness gating) in the on-phase states
  always_comb begin
    lit_s = 1'b0;
    case (state_r)
      S_ON, S_BLINK_ON, S_PULSE: lit_s = 1'b1;
      default:                   lit_s = 1'b0;
    endcase
  end

  // state, counters, PWM and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= S_OFF;
      ms_cnt_r    <= 8'd0;
      period_r    <= 8'd1;
      bright_r    <= 8'd255;
      pwm_r       <= 8'd0;
      led_r       <= 1'b0;
      cmd_ready_r <= 1'b1;
    end else begin
      state_r     <= state_nxt_s;
      ms_cnt_r    <= ms_cnt_nxt_s;
      period_r    <= period_nxt_s;
      bright_r    <= bright_nxt_s;
      pwm_r       <= pwm_r + 8'd1;
      // bright==255 means full on, so the 255th PWM slot is not lost
      led_r       <= lit_s && ((bright_r == 8'd255) || (pwm_r < bright_r));
      cmd_ready_r <= (state_nxt_s != S_PULSE);
    end
  end

  assign led           = led_r;
  assign bus.cmd_ready = cmd_ready_r;

endmodule

// File: tb/tb_led_driver.sv
// Self-checking bench for led_driver (CLK_FREQ=1000, TICK_HZ=100 -> 10 clocks per ms).
// The reference model describes the LED from the time elapsed since the last command.
module tb_led_driver;
  import led_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic led;

  led_driver_if bus ();

  led_driver #(
    .CLK_FREQ (1000),
    .TICK_HZ  (100)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .led   (led)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // model: 0 off, 1 on, 2 blink, 3 pulse; m_len = half-period or pulse width in clocks
  int m_mode, m_start, m_len, m_bright, m_edge;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, obs, exp, m_edge);
    end
  endtask

  function automatic bit m_lit();
    int k = m_edge - m_start;
    case (m_mode)
      1:       return 1'b1;
      2:       return ((k / m_len) % 2) == 0;
      3:       return k < m_len;
      default: return 1'b0;
    endcase
  endfunction

  function automatic bit m_ready();
    return !(m_mode == 3 && (m_edge - m_start) < m_len);
  endfunction

  task automatic model_reset();
    m_mode = 0; m_start = 0; m_len = 10; m_bright = 255; m_edge = 0;
  endtask

  // one clock: drive at negedge, let the edge happen, check #1 after it, return at next negedge
  task automatic cycle(input bit v, input int md, input int arg, output bit acc);
    bit lit_p;
    int br_p, pwm_p;
    bit exp_led;
    bus.cmd_valid = v;
    bus.cmd_mode  = md[2:0];
    bus.cmd_arg   = arg[7:0];
    acc   = v && m_ready();
    lit_p = m_lit();
    br_p  = m_bright;
    pwm_p = m_edge % 256;
    @(posedge clk);
    m_edge++;
    if (acc) begin
      case (md)
        0: m_mode = 0;
        1: m_mode = 1;
        2, 3: begin
          m_mode  = md;
          m_start = m_edge;
          m_len   = ((arg == 0) ? 1 : arg) * 10;
        end
        4:       m_bright = arg;
        default: m_bright = m_bright;
      endcase
    end
    exp_led = lit_p && (br_p == 255 || pwm_p < br_p);
    #1;
    check_val("led", led, exp_led);
    check_val("cmd_ready", bus.cmd_ready, m_ready());
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) cycle(1'b0, 0, 0, acc);
  endtask

  task automatic send(input int md, input int arg);
    bit acc;
    cycle(1'b1, md, arg, acc);
    bus.cmd_valid = 1'b0;
  endtask

  task automatic do_reset();
    bus.cmd_valid = 1'b0;
    bus.cmd_mode  = 3'd0;
    bus.cmd_arg   = 8'd0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_val("reset_led", led, 1'b0);
    check_val("reset_ready", bus.cmd_ready, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    bit acc;
    int cnt;
    model_reset();
    do_reset();

    // ON, then BLINK 3 with an OFF mid-period
    send(1, 0);     idle(5);
    send(2, 3);     idle(130);
    send(2, 3);     idle(45);
    send(0, 0);     idle(3);

    // PULSE 2 with ON held until accepted: accepted on the 21st held cycle
    send(3, 2);
    cnt = 0;
    acc = 1'b0;
    while (!acc && cnt < 100) begin
      cycle(1'b1, 1, 0, acc);
      cnt++;
    end
    bus.cmd_valid = 1'b0;
    check_val("pulse_hold_cycles", cnt, 21);
    idle(5);

    // brightness 64: exactly 64 lit cycles in any 256-cycle window
    send(4, 64);
    send(1, 0);
    cnt = 0;
    for (int i = 0; i < 256; i++) begin
      cycle(1'b0, 0, 0, acc);
      if (led === 1'b1) cnt++;
    end
    check_val("bright64_duty", cnt, 64);
    send(4, 0);     idle(300);
    send(4, 255);   idle(20);

    // BLINK arg 0 behaves as 1 ms, reserved opcode has no effect
    send(2, 0);     idle(45);
    send(1, 0);     idle(3);
    send(6, 8'h5A); idle(5);

    // reset 5 cycles into a PULSE
    send(3, 5);     idle(4);
    #2 rst_n = 1'b0;
    #1;
    check_val("midreset_led", led, 1'b0);
    check_val("midreset_ready", bus.cmd_ready, 1'b1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    send(1, 0);     idle(300);

    // randomized commands
    for (int i = 0; i < 3000; i++) begin
      int md, arg;
      bit v;
      v   = ($urandom_range(0, 15) == 0);
      md  = $urandom_range(0, 7);
      arg = (md == 4) ? $urandom_range(0, 255) : $urandom_range(0, 3);
      cycle(v, md, arg, acc);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
